tile_map_controller: RTL and testbench

TILE_MAP_CONTROLLER -- requirements
Module: tile_map_controller

---
 rtl/tile_map_controller.sv | 116 +++++++++++
 tb/tb_tile_map_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_controller.sv
// 30x40 tile occupancy map with single-tile writes and a row-clear pass
// that removes full rows bottom-up and shifts the rows above them down.
module tile_map_controller (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_en_i,
    input  logic [4:0]          wr_row_i,
    input  logic [5:0]          wr_col_i,
    input  logic                wr_val_i,
    input  logic                start_i,
    input  logic                clear_all_i,
    output logic [0:29][0:39]   tile_o,
    output logic                ready_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [15:0]         lines_cleared_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]         rst_sync_q;
    logic               rst_int_n;
    logic [1:0]         state_q, state_d;
    logic [4:0]         r_q, r_d;
    logic [4:0]         s_q, s_d;
    logic [0:29][0:39]  tile_q, tile_d;
    logic [15:0]        lines_q, lines_d;

    // Assert asynchronously, release on a clock edge so no flop sees a runt release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        s_d     = s_q;
        tile_d  = tile_q;
        lines_d = lines_q;
        if (clear_all_i) begin
            state_d = IDLE;
            r_d     = 5'd0;
            s_d     = 5'd0;
            tile_d  = '0;
            lines_d = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_en_i && (wr_row_i < 5'd30) && (wr_col_i < 6'd40)) begin
                        tile_d[wr_row_i][wr_col_i] = wr_val_i;
                    end
                    if (start_i) begin
                        state_d = SCAN;
                        r_d     = 5'd29;
                    end
                end
                SCAN: begin
                    if (&tile_q[r_q]) begin
                        state_d = SHIFT;
                        s_d     = r_q;
                    end else if (r_q == 5'd0) begin
                        state_d = DONE;
                    end else begin
                        r_d = r_q - 5'd1;
                    end
                end
                SHIFT: begin
                    // r stays put so the row shifted into it is examined again.
                    if (s_q != 5'd0) begin
                        tile_d[s_q] = tile_q[s_q - 5'd1];
                        s_d         = s_q - 5'd1;
                    end else begin
                        tile_d[0] = '0;
                        lines_d   = lines_q + 16'd1;
                        state_d   = SCAN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= IDLE;
            r_q     <= 5'd0;
            s_q     <= 5'd0;
            tile_q  <= '0;
            lines_q <= 16'd0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            s_q     <= s_d;
            tile_q  <= tile_d;
            lines_q <= lines_d;
        end
    end

    assign tile_o          = tile_q;
    assign lines_cleared_o = lines_q;
    assign ready_o         = (state_q == IDLE);
    assign busy_o          = (state_q == SCAN) || (state_q == SHIFT);
    assign done_o          = (state_q == DONE);

endmodule

// File: tb/tb_tile_map_controller.sv
// Directed bench for tile_map_controller: writes, clear passes, timing,
// ignored requests while busy, reset and clear_all mid-pass.
module tb_tile_map_controller;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wr_en;
    logic [4:0]         wr_row;
    logic [5:0]         wr_col;
    logic               wr_val;
    logic               start;
    logic               clear_all;
    logic [0:29][0:39]  tile;
    logic               ready;
    logic               busy;
    logic               done;
    logic [15:0]        lines_cleared;

    logic [0:29][0:39]  exp_tile;
    int                 n_chk = 0;
    int                 n_pass = 0;

    tile_map_controller dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .wr_en_i         (wr_en),
        .wr_row_i        (wr_row),
        .wr_col_i        (wr_col),
        .wr_val_i        (wr_val),
        .start_i         (start),
        .clear_all_i     (clear_all),
        .tile_o          (tile),
        .ready_o         (ready),
        .busy_o          (busy),
        .done_o          (done),
        .lines_cleared_o (lines_cleared)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1199:0] obs, input logic [1199:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int row, input int col, input logic val);
        wr_en  = 1'b1;
        wr_row = 5'(row);
        wr_col = 6'(col);
        wr_val = val;
        tick();
        wr_en  = 1'b0;
        if (row < 30 && col < 40) exp_tile[row][col] = val;
    endtask

    task automatic do_clear_all();
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        exp_tile  = '0;
    endtask

    task automatic fill_row(input int row);
        for (int c = 0; c < 40; c++) wr(row, c, 1'b1);
    endtask

    // Edges counted from the one that samples start to the first one after which done is high.
    task automatic run_pass(input string tag, input int exp_lat, input int inj_wr, input int inj_st);
        int edges;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        edges = 1;
        while (!done && edges < 300) begin
            if (edges == inj_wr) begin
                wr_en  = 1'b1;
                wr_row = 5'd29;
                wr_col = 6'd0;
                wr_val = 1'b1;
            end
            if (edges == inj_st) start = 1'b1;
            tick();
            edges++;
            wr_en = 1'b0;
            start = 1'b0;
        end
        chk({tag, "_latency"}, 1200'(edges), 1200'(exp_lat));
        tick();
        chk({tag, "_done_one_cycle"}, 1200'(done), 1200'(0));
        chk({tag, "_ready_back"}, 1200'(ready), 1200'(1));
    endtask

    initial begin
        int dones;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_row    = '0;
        wr_col    = '0;
        wr_val    = 1'b0;
        start     = 1'b0;
        clear_all = 1'b0;
        exp_tile  = '0;
        #2;
        chk("rst_ready", 1200'(ready), 1200'(1));
        chk("rst_busy", 1200'(busy), 1200'(0));
        chk("rst_done", 1200'(done), 1200'(0));
        chk("rst_lines", 1200'(lines_cleared), 1200'(0));
        chk("rst_tile", tile, '0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();

        // Empty grid: 30 scan cycles then done.
        run_pass("empty", 31, -1, -1);
        chk("empty_tile", tile, '0);
        chk("empty_lines", 1200'(lines_cleared), 1200'(0));

        // Single writes, including two out-of-range ones.
        wr(5, 7, 1'b1);
        wr(29, 39, 1'b1);
        wr(30, 0, 1'b1);
        wr(3, 40, 1'b1);
        chk("write_tile", tile, exp_tile);
        chk("write_bit_5_7", 1200'(tile[5][7]), 1200'(1));
        chk("write_bit_29_39", 1200'(tile[29][39]), 1200'(1));

        do_clear_all();
        chk("clear_all_tile", tile, '0);

        // One full row at the bottom with a lone bit above it.
        fill_row(29);
        wr(28, 3, 1'b1);
        run_pass("one_row", 62, -1, -1);
        exp_tile = '0;
        exp_tile[29][3] = 1'b1;
        chk("one_row_tile", tile, exp_tile);
        chk("one_row_lines", 1200'(lines_cleared), 1200'(1));

        // Two full rows; the last write of row 28 shares its cycle with start.
        do_clear_all();
        chk("clear_all_lines", 1200'(lines_cleared), 1200'(0));
        fill_row(29);
        for (int c = 0; c < 39; c++) wr(28, c, 1'b1);
        wr_en  = 1'b1;
        wr_row = 5'd28;
        wr_col = 6'd39;
        wr_val = 1'b1;
        // scan + shift 30 + rescan + shift 30 + 30 scans + done
        run_pass("two_rows", 93, -1, -1);
        chk("two_rows_tile", tile, '0);
        chk("two_rows_lines", 1200'(lines_cleared), 1200'(2));

        // Write during SHIFT and start during SCAN must both be dropped.
        do_clear_all();
        fill_row(29);
        wr(28, 3, 1'b1);
        run_pass("ignore", 62, 5, 40);
        exp_tile = '0;
        exp_tile[29][3] = 1'b1;
        chk("ignore_tile", tile, exp_tile);
        chk("ignore_lines", 1200'(lines_cleared), 1200'(1));

        // Reset in the middle of a shift.
        fill_row(29);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("midshift_busy", 1200'(busy), 1200'(1));
        rst_n = 1'b0;
        #1;
        chk("midshift_rst_tile", tile, '0);
        chk("midshift_rst_lines", 1200'(lines_cleared), 1200'(0));
        chk("midshift_rst_ready", 1200'(ready), 1200'(1));
        chk("midshift_rst_busy", 1200'(busy), 1200'(0));
        chk("midshift_rst_done", 1200'(done), 1200'(0));
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        exp_tile = '0;
        chk("post_rst_ready", 1200'(ready), 1200'(1));

        // clear_all while scanning after one row has been removed.
        fill_row(29);
        wr(5, 2, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (34) tick();
        chk("midscan_busy", 1200'(busy), 1200'(1));
        chk("midscan_lines", 1200'(lines_cleared), 1200'(1));
        do_clear_all();
        chk("clr_ready", 1200'(ready), 1200'(1));
        chk("clr_busy", 1200'(busy), 1200'(0));
        chk("clr_tile", tile, '0);
        chk("clr_lines", 1200'(lines_cleared), 1200'(0));
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            tick();
        end
        chk("clr_no_done", 1200'(dones), 1200'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
